// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register-file write decoder
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef struct packed {
        logic              valid;
        logic              en;
        logic [ADDR_W-1:0] addr;
    } wr_req_t;

    // True when a stage entry will really write a register (the zero register is never written)
    function automatic logic writes_reg(input wr_req_t r, input int zero_reg);
        return r.valid && r.en && ((zero_reg < 0) || (int'(r.addr) != zero_reg));
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - generic N-to-2^N one-hot decoder with enable
module onehot_dec #(
    parameter int N = 5
) (
    input  logic [N-1:0]    in,
    input  logic            en,
    output logic [2**N-1:0] out
);

    // Single bit set at the selected index, all-zero when disabled
    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_decoder.sv
// rtl/regfile_wr_decoder.sv - pipelined register-file write decoder with pending-write scoreboard
module regfile_wr_decoder #(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int LAT      = 1,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG,
    parameter int DELAY    = 50,
    localparam int NREGS   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_en,
    input  logic              stall,
    input  logic              flush,
    output logic              we_valid,
    output logic [NREGS-1:0]  we_onehot,
    output logic [NREGS-1:0]  pend,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_hazard_a,
    output logic              rd_hazard_b,
    output logic              err_onehot
);

    import regfile_pkg::*;

    // Stage entries are the shared struct, so the address width is tied to the package
    if (ADDR_W != regfile_pkg::ADDR_W) begin : g_addr_w_check
        $error("regfile_wr_decoder: ADDR_W must match regfile_pkg::ADDR_W");
    end
    if (LAT < 1 || LAT > 3) begin : g_lat_check
        $error("regfile_wr_decoder: LAT must be in 1..3");
    end
    if (DELAY < 0) begin : g_delay_check
        $error("regfile_wr_decoder: DELAY must be non-negative");
    end

    wr_req_t            stage_q   [LAT];
    logic [NREGS-1:0]   stage_dec [LAT];
    logic [LAT-1:0]     stage_wr;
    wr_req_t            last;
    logic               we_en;

    assign req_ready = ~stall;

    // Request pipeline: flush empties every slot, stall freezes, otherwise shift one slot per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else if (!stall) begin
            if (req_valid) begin
                stage_q[0] <= '{valid: 1'b1, en: req_en, addr: req_addr};
            end else begin
                stage_q[0] <= '0;
            end
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign last     = stage_q[LAT-1];
    assign we_valid = last.valid;
    assign we_en    = writes_reg(last, ZERO_REG);

    onehot_dec #(.N(ADDR_W)) u_we_dec (
        .in  (last.addr),
        .en  (we_en),
        .out (we_onehot)
    );

    for (genvar s = 0; s < LAT; s++) begin : g_stage_dec
        assign stage_wr[s] = writes_reg(stage_q[s], ZERO_REG);

        onehot_dec #(.N(ADDR_W)) u_pend_dec (
            .in  (stage_q[s].addr),
            .en  (stage_wr[s]),
            .out (stage_dec[s])
        );
    end

    // A register is pending while any stage holds a real write to it
    always_comb begin
        pend = '0;
        for (int s = 0; s < LAT; s++) begin
            pend = pend | stage_dec[s];
        end
    end

    assign rd_hazard_a = pend[rd_addr_a];
    assign rd_hazard_b = pend[rd_addr_b];

    // Sticky checker: more than one write enable at once (x & (x-1) is non-zero)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_onehot <= 1'b0;
        end else if ((we_onehot & (we_onehot - NREGS'(1))) != '0) begin
            err_onehot <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// tb/tb_regfile_wr_decoder.sv - scoreboard bench for regfile_wr_decoder at LAT=1 and LAT=3
module tb_regfile_wr_decoder;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic [4:0]  req_addr;
    logic        req_en;
    logic        stall;
    logic        flush;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;

    logic        req_ready   [2];
    logic        we_valid    [2];
    logic [31:0] we_onehot   [2];
    logic [31:0] pend        [2];
    logic        rd_hazard_a [2];
    logic        rd_hazard_b [2];
    logic        err_onehot  [2];

    typedef struct {
        int          due;
        logic [31:0] oh;
    } exp_t;

    exp_t        sbq [2][$];
    logic        cur_valid [2];
    logic [31:0] cur_oh    [2];
    int          cyc;
    int          stall_cnt;
    int          kind;
    int          n_checks;
    int          n_fail;

    regfile_wr_decoder #(.LAT(1)) u_dut0 (
        .clk (clk), .reset_n (reset_n),
        .req_valid (req_valid), .req_ready (req_ready[0]),
        .req_addr (req_addr), .req_en (req_en),
        .stall (stall), .flush (flush),
        .we_valid (we_valid[0]), .we_onehot (we_onehot[0]), .pend (pend[0]),
        .rd_addr_a (rd_addr_a), .rd_addr_b (rd_addr_b),
        .rd_hazard_a (rd_hazard_a[0]), .rd_hazard_b (rd_hazard_b[0]),
        .err_onehot (err_onehot[0])
    );

    regfile_wr_decoder #(.LAT(3)) u_dut1 (
        .clk (clk), .reset_n (reset_n),
        .req_valid (req_valid), .req_ready (req_ready[1]),
        .req_addr (req_addr), .req_en (req_en),
        .stall (stall), .flush (flush),
        .we_valid (we_valid[1]), .we_onehot (we_onehot[1]), .pend (pend[1]),
        .rd_addr_a (rd_addr_a), .rd_addr_b (rd_addr_b),
        .rd_hazard_a (rd_hazard_a[1]), .rd_hazard_b (rd_hazard_b[1]),
        .err_onehot (err_onehot[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] oh_of(input logic en, input logic [4:0] a);
        return (en && a != 5'd31) ? (32'd1 << a) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic drive(input logic v, input logic en, input logic [4:0] a,
                         input logic st, input logic fl);
        req_valid = v;
        req_en    = en;
        req_addr  = a;
        stall     = st;
        flush     = fl;
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            sbq[d].delete();
            cur_valid[d] = 1'b0;
            cur_oh[d]    = '0;
        end
    endtask

    task automatic monitor();
        logic [31:0] p;
        int          now;
        now = cyc - stall_cnt;
        for (int d = 0; d < 2; d++) begin
            if (kind >= 2) begin
                cur_valid[d] = 1'b0;
                cur_oh[d]    = '0;
            end else if (kind == 0) begin
                if (sbq[d].size() > 0 && sbq[d][0].due == now) begin
                    cur_valid[d] = 1'b1;
                    cur_oh[d]    = sbq[d].pop_front().oh;
                end else begin
                    cur_valid[d] = 1'b0;
                    cur_oh[d]    = '0;
                end
            end
            p = cur_oh[d];
            foreach (sbq[d][k]) p = p | sbq[d][k].oh;
            check($sformatf("d%0d we_valid c%0d", d, cyc), 32'(we_valid[d]), 32'(cur_valid[d]));
            check($sformatf("d%0d we_onehot c%0d", d, cyc), we_onehot[d], cur_oh[d]);
            check($sformatf("d%0d pend c%0d", d, cyc), pend[d], p);
            check($sformatf("d%0d req_ready c%0d", d, cyc), 32'(req_ready[d]), 32'(!stall));
            check($sformatf("d%0d hazard_a c%0d", d, cyc), 32'(rd_hazard_a[d]), 32'(p[rd_addr_a]));
            check($sformatf("d%0d hazard_b c%0d", d, cyc), 32'(rd_hazard_b[d]), 32'(p[rd_addr_b]));
            check($sformatf("d%0d err_onehot c%0d", d, cyc), 32'(err_onehot[d]), 32'd0);
        end
    endtask

    // Accepted requests are pushed with their due cycle at the edge, then checked half a cycle later
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            kind = 3;
            model_clear();
        end else if (flush) begin
            kind = 2;
            model_clear();
        end else if (stall) begin
            kind = 1;
            stall_cnt++;
        end else begin
            kind = 0;
            if (req_valid) begin
                for (int d = 0; d < 2; d++) begin
                    e.due = cyc + lat_of(d) - 1 - stall_cnt;
                    e.oh  = oh_of(req_en, req_addr);
                    sbq[d].push_back(e);
                end
            end
        end
        @(negedge clk);
        monitor();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        stall_cnt = 0;
        kind      = 3;
        reset_n   = 1'b0;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd3;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        model_clear();
        tick();
        tick();
        reset_n = 1'b1;

        // Two requests in flight, then asynchronous reset between clock edges
        drive(1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        tick();
        check("pre-reset pend d1", pend[1], 32'h0000_0018);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("async reset we_onehot d%0d", d), we_onehot[d], 32'd0);
            check($sformatf("async reset pend d%0d", d), pend[d], 32'd0);
            check($sformatf("async reset we_valid d%0d", d), 32'(we_valid[d]), 32'd0);
        end
        model_clear();
        tick();
        @(negedge clk);
        reset_n = 1'b1;

        // Address sweep, one request per cycle
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b1, 5'(a), 1'b0, 1'b0);
            tick();
            check($sformatf("sweep lat1 addr %0d", a), we_onehot[0],
                  (a == 31) ? 32'd0 : (32'd1 << a));
        end
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (4) tick();

        // Back-to-back writes to register 5 keep it pending for four cycles at LAT=3
        drive(1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("pend5 d1 k%0d", k), 32'(pend[1][5]), 32'(k < 4));
            check($sformatf("hazard_a5 d1 k%0d", k), 32'(rd_hazard_a[1]), 32'(k < 4));
            if (k == 1) drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        end

        // Stall with register 7 in the last stage; the stalled request must never enter
        drive(1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("addr7 at last stage d1", we_onehot[1], 32'h0000_0080);
        drive(1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("stall hold onehot k%0d", k), we_onehot[1], 32'h0000_0080);
            check($sformatf("stall ready k%0d", k), 32'(req_ready[1]), 32'd0);
        end
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (4) tick();

        // Flush kills in-flight work and the request presented with it
        drive(1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd9, 1'b0, 1'b1);
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("flush pend d%0d", d), pend[d], 32'd0);
            check($sformatf("flush we_valid d%0d", d), 32'(we_valid[d]), 32'd0);
        end
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("no addr9 d1 k%0d", k), 32'(we_onehot[1][9]), 32'd0);
        end

        // Flush wins over stall
        drive(1'b1, 1'b1, 5'd10, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        check("flush over stall pend d1", pend[1], 32'd0);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();

        // Bubble and zero-register requests travel but never write or mark pending
        drive(1'b1, 1'b0, 5'd6, 1'b0, 1'b0);
        tick();
        check("bubble we_valid d0", 32'(we_valid[0]), 32'd1);
        check("bubble we_onehot d0", we_onehot[0], 32'd0);
        check("bubble pend d1", pend[1], 32'd0);
        drive(1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
        tick();
        check("zero reg we_valid d0", 32'(we_valid[0]), 32'd1);
        check("zero reg we_onehot d0", we_onehot[0], 32'd0);
        check("zero reg pend d1", pend[1], 32'd0);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (4) tick();

        for (int d = 0; d < 2; d++) begin
            check($sformatf("scoreboard drained d%0d", d), 32'(sbq[d].size()), 32'd0);
            check($sformatf("final err_onehot d%0d", d), 32'(err_onehot[d]), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
